// File: rtl/fir_inverse_if.sv
// Sample/result bus for the fir_inverse all-pole filter.
interface fir_inverse_if #(parameter int N = 16);
  logic                en;
  logic signed [N-1:0] X;
  logic signed [N-1:0] a1, a2, a3, a4;
  logic signed [N-1:0] Y;
  logic                valid;
  logic                busy;
  logic                overrun;

  modport master (output en, X, a1, a2, a3, a4,
                  input  Y, valid, busy, overrun);
  modport slave  (input  en, X, a1, a2, a3, a4,
                  output Y, valid, busy, overrun);
endinterface

// File: rtl/fir_inverse.sv
// Time-multiplexed 4-tap all-pole IIR: y = x - sum(ak*y[n-k]), one shared
// multiplier, four MAC cycles per sample, saturated Q1.(N-1) result.
module fir_inverse #(parameter int N = 16) (
  input  logic           clk,
  input  logic           rst,
  fir_inverse_if.slave   bus
);
  localparam int ACC_W = 2*N + 3;
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2**(N-1) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(2**(N-1)));

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic [1:0]              k;      // tap index minus one
  logic [3:0][N-1:0]       hist;   // hist[0] = y[n-1] .. hist[3] = y[n-4]
  logic signed [N-1:0]     a_sel, h_sel, r;
  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] sh;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = MAC;
      MAC:     if (k == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_sel = bus.a1;
    case (k)
      2'd0:    a_sel = bus.a1;
      2'd1:    a_sel = bus.a2;
      2'd2:    a_sel = bus.a3;
      default: a_sel = bus.a4;
    endcase
    h_sel = $signed(hist[k]);
    prod  = a_sel * h_sel;
  end

  // Floor shift back to Q1.(N-1), then clamp; the clamped value feeds history.
  always_comb begin
    sh = acc >>> (N-1);
    if (sh > MAXV)      r = MAXV[N-1:0];
    else if (sh < MINV) r = MINV[N-1:0];
    else                r = sh[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      k           <= '0;
      hist        <= '0;
      bus.Y       <= '0;
      bus.valid   <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      if (bus.en && state != IDLE) bus.overrun <= 1'b1;
      case (state)
        IDLE: if (bus.en) begin
          acc <= {{4{bus.X[N-1]}}, bus.X, {(N-1){1'b0}}};
          k   <= '0;
        end
        MAC: begin
          acc <= acc - {{3{prod[2*N-1]}}, prod};
          k   <= k + 2'd1;
        end
        DONE: begin
          bus.Y     <= r;
          bus.valid <= 1'b1;
          hist      <= {hist[2:0], r};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
endmodule
